enigma_plugboard: RTL and testbench

- Stecker (plugboard) stage at the front of the Enigma datapath.
- Swaps configured pairs of uppercase ASCII letters. Letters with no pair pass through unchanged.
- Drives the first rotor's `din`/`valid` through a registered valid/ready stream.
- The swap map is its own inverse, so the same block serves encryption and decryption and has no `dec` input.

---
 rtl/enigma_pkg.sv | 20 ++
 rtl/enigma_stream_reg.sv | 30 +++
 rtl/enigma_plugboard.sv | 128 ++++++++++++
 tb/tb_enigma_plugboard.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared Enigma datapath definitions: alphabet constants, letter index type,
// ASCII helpers and the plugboard state encoding.
package enigma_pkg;

    localparam int ASCII_A = 65;
    localparam int ALPHA_N = 26;

    typedef logic [4:0] letter_t;

    typedef enum logic {PB_IDLE, PB_CLEAR} pb_state_t;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= 8'(ASCII_A)) && (c < 8'(ASCII_A + ALPHA_N));
    endfunction

    function automatic letter_t to_idx(input logic [7:0] c);
        return letter_t'(c - 8'(ASCII_A));
    endfunction

endpackage

// File: rtl/enigma_stream_reg.sv
// One-deep valid/ready output register shared by the Enigma pipeline stages.
// Handshake: a beat transfers on a clock edge where valid && ready; data holds while valid && !ready.
module enigma_stream_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/enigma_plugboard.sv
// Enigma stecker stage: self-inverse letter swap table feeding a registered stream.
// Build option ENIGMA_PLUGBOARD_CHECK_EN rejects illegal or conflicting pair writes.
module enigma_plugboard
    import enigma_pkg::*;
#(
    parameter int MAX_PAIRS = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cfg_clr,
    input  logic       cfg_wr,
    input  logic [7:0] cfg_a,
    input  logic [7:0] cfg_b,
    output logic       cfg_ready,
    output logic       cfg_err,
    output logic [4:0] pair_cnt,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_char,
    output logic       out_swapped,
    output logic       fsm_state
);

    pb_state_t state;
    letter_t   k;
    letter_t   tbl [ALPHA_N];
    logic      err_q;

    letter_t idx_in, idx_a, idx_b;
    letter_t map_in, map_a, map_b;
    logic    wr_ok, wr_rej;
    logic [4:0] cnt_next;
    logic [7:0] mapped;
    logic    sr_in_ready;

    assign idx_in = to_idx(in_char);
    assign idx_a  = to_idx(cfg_a);
    assign idx_b  = to_idx(cfg_b);

    // Loop lookups keep every table read inside the 26 real entries.
    always_comb begin
        map_in = idx_in;
        map_a  = idx_a;
        map_b  = idx_b;
        for (int i = 0; i < ALPHA_N; i++) begin
            if (idx_in == letter_t'(i)) map_in = tbl[i];
            if (idx_a == letter_t'(i))  map_a  = tbl[i];
            if (idx_b == letter_t'(i))  map_b  = tbl[i];
        end
    end

`ifdef ENIGMA_PLUGBOARD_CHECK_EN
    assign wr_ok = is_letter(cfg_a) && is_letter(cfg_b) && (cfg_a != cfg_b)
                && (map_a == idx_a) && (map_b == idx_b)
                && (pair_cnt != 5'(MAX_PAIRS));
    assign wr_rej   = !wr_ok;
    assign cnt_next = pair_cnt + 5'd1;
`else
    assign wr_ok    = is_letter(cfg_a) && is_letter(cfg_b);
    assign wr_rej   = 1'b0;
    assign cnt_next = (pair_cnt == 5'd31) ? pair_cnt : pair_cnt + 5'd1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= PB_IDLE;
            k        <= '0;
            pair_cnt <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < ALPHA_N; i++) tbl[i] <= letter_t'(i);
        end else begin
            err_q <= 1'b0;
            case (state)
                PB_IDLE: begin
                    if (cfg_clr) begin
                        state    <= PB_CLEAR;
                        k        <= '0;
                        pair_cnt <= '0;
                    end else if (cfg_wr) begin
                        if (wr_ok) begin
                            for (int i = 0; i < ALPHA_N; i++) begin
                                if (idx_a == letter_t'(i)) tbl[i] <= idx_b;
                                if (idx_b == letter_t'(i)) tbl[i] <= idx_a;
                            end
                            pair_cnt <= cnt_next;
                        end else begin
                            err_q <= wr_rej;
                        end
                    end
                end
                PB_CLEAR: begin
                    for (int i = 0; i < ALPHA_N; i++) begin
                        if (k == letter_t'(i)) tbl[i] <= k;
                    end
                    if (k == letter_t'(ALPHA_N - 1)) begin
                        state <= PB_IDLE;
                    end else begin
                        k <= k + 5'd1;
                    end
                end
                default: state <= PB_IDLE;
            endcase
        end
    end

    assign cfg_err   = err_q;
    assign cfg_ready = (state == PB_IDLE);
    assign fsm_state = state;
    assign in_ready  = (state == PB_IDLE) && sr_in_ready;

    // Reads the table as it stood before any same-cycle pair write.
    assign mapped = is_letter(in_char) ? (8'(map_in) + 8'(ASCII_A)) : in_char;

    enigma_stream_reg #(.W(9)) u_out (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid && (state == PB_IDLE)),
        .in_ready  (sr_in_ready),
        .in_data   ({mapped != in_char, mapped}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_swapped, out_char})
    );

endmodule

// File: tb/tb_enigma_plugboard.sv
// Scoreboard bench for enigma_plugboard: letter-table model, directed scenarios, random traffic.
module tb_enigma_plugboard;

    localparam int MAXP = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_clr = 1'b0, cfg_wr = 1'b0;
    logic [7:0] cfg_a = 8'd0, cfg_b = 8'd0;
    logic       cfg_ready, cfg_err;
    logic [4:0] pair_cnt;
    logic       in_valid = 1'b0, in_ready;
    logic [7:0] in_char = 8'd0;
    logic       out_valid, out_ready = 1'b1;
    logic [7:0] out_char;
    logic       out_swapped;
    logic       fsm_state;

    always #5 clk = ~clk;

    enigma_plugboard #(.MAX_PAIRS(MAXP)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_clr(cfg_clr), .cfg_wr(cfg_wr), .cfg_a(cfg_a), .cfg_b(cfg_b),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .pair_cnt(pair_cnt),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_char(out_char), .out_swapped(out_swapped),
        .fsm_state(fsm_state)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: table as an int array, output occupancy as the expected queue.
    logic [8:0] exp_q[$];
    int  m_tbl [26];
    int  m_cnt;
    int  m_clr_left;
    bit  m_err;
    bit  m_idle;
    bit  m_in_ready;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_l(input logic [7:0] c);
        return (c >= 8'd65) && (c <= 8'd90);
    endfunction

    function automatic void m_identity();
        for (int i = 0; i < 26; i++) m_tbl[i] = i;
    endfunction

    function automatic void m_reset();
        m_identity();
        m_cnt = 0;
        m_clr_left = 0;
        m_err = 1'b0;
        exp_q.delete();
    endfunction

    function automatic logic [8:0] m_map(input logic [7:0] c);
        logic [7:0] m;
        m = is_l(c) ? 8'(m_tbl[c - 8'd65] + 65) : c;
        return {m != c, m};
    endfunction

    function automatic void m_write(input logic [7:0] a, input logic [7:0] b);
        int ia, ib;
        if (!(is_l(a) && is_l(b))) begin
`ifdef ENIGMA_PLUGBOARD_CHECK_EN
            m_err = 1'b1;
`endif
            return;
        end
        ia = int'(a) - 65;
        ib = int'(b) - 65;
`ifdef ENIGMA_PLUGBOARD_CHECK_EN
        if (a == b || m_tbl[ia] != ia || m_tbl[ib] != ib || m_cnt == MAXP) begin
            m_err = 1'b1;
            return;
        end
        m_cnt++;
`else
        if (m_cnt < 31) m_cnt++;
`endif
        m_tbl[ia] = ib;
        m_tbl[ib] = ia;
    endfunction

    // Monitor: compares every visible output once per cycle, then advances the model.
    always @(negedge clk) begin
        if (!reset_n) begin
            m_reset();
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_char", int'(out_char), 0);
            check("rst_out_swapped", int'(out_swapped), 0);
            check("rst_cfg_ready", int'(cfg_ready), 1);
            check("rst_in_ready", int'(in_ready), 1);
            check("rst_pair_cnt", int'(pair_cnt), 0);
            check("rst_cfg_err", int'(cfg_err), 0);
        end else begin
            m_idle = (m_clr_left == 0);
            m_in_ready = m_idle && (exp_q.size() == 0 || out_ready);
            check("in_ready", int'(in_ready), int'(m_in_ready));
            check("cfg_ready", int'(cfg_ready), int'(m_idle));
            check("pair_cnt", int'(pair_cnt), m_cnt);
            check("cfg_err", int'(cfg_err), int'(m_err));
            check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("out_char", int'(out_char), int'(exp_q[0][7:0]));
                check("out_swapped", int'(out_swapped), int'(exp_q[0][8]));
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && m_in_ready) exp_q.push_back(m_map(in_char));
            m_err = 1'b0;
            if (!m_idle) begin
                m_clr_left--;
            end else if (cfg_clr) begin
                m_clr_left = 26;
                m_cnt = 0;
                m_identity();
            end else if (cfg_wr) begin
                m_write(cfg_a, cfg_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        int  n;
        bit  acc;
        in_valid = 1'b1;
        in_char  = c;
        acc = 1'b0;
        for (n = 0; n < 200 && !acc; n++) begin
            acc = in_ready;
            tick();
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] b);
        int n;
        for (n = 0; n < 200 && !cfg_ready; n++) tick();
        if (!cfg_ready) check("cfg_timeout", 0, 1);
        cfg_wr = 1'b1;
        cfg_a  = a;
        cfg_b  = b;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (n = 0; n < 60 && (exp_q.size() != 0 || !cfg_ready); n++) tick();
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] hello [5];
        hello = '{8'd72, 8'd69, 8'd76, 8'd76, 8'd79};

        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Pass-through of an unpaired word, back to back.
        out_ready = 1'b1;
        foreach (hello[i]) send(hello[i]);
        send(8'd32);
        send(8'd97);
        drain();

        cfg_write("A", "B");
        send(8'd65);
        send(8'd66);
        send(8'd67);
        drain();

`ifdef ENIGMA_PLUGBOARD_CHECK_EN
        cfg_write("A", "C");
        cfg_write("Q", "Q");
        cfg_write("a", "D");
        for (int i = 0; i < 10; i++) cfg_write(8'(67 + 2 * i), 8'(68 + 2 * i));
        send(8'd65);
        send(8'd67);
        drain();
`else
        cfg_write("A", "C");
        send(8'd65);
        send(8'd66);
        send(8'd67);
        cfg_write("a", "D");
        drain();
`endif

        // Output stall: first char sits in the register, second waits five cycles.
        out_ready = 1'b0;
        send("S");
        in_valid = 1'b1;
        in_char  = "T";
        repeat (5) tick();
        out_ready = 1'b1;
        send("T");
        drain();

        // Clear wins over a simultaneous write; input blocked for the sweep.
        cfg_clr = 1'b1;
        cfg_wr  = 1'b1;
        cfg_a   = "B";
        cfg_b   = "C";
        tick();
        cfg_clr = 1'b0;
        cfg_wr  = 1'b0;
        send(8'd66);
        send(8'd65);
        drain();

        // Reset in the middle of the sweep.
        cfg_write("X", "Y");
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        send("X");
        drain();

        // Random traffic with occasional reconfiguration.
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_char   = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(65, 90))
                                                    : 8'($urandom_range(0, 255));
            cfg_wr    = ($urandom_range(0, 39) == 0);
            cfg_a     = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                    : 8'($urandom_range(65, 90));
            cfg_b     = 8'($urandom_range(65, 90));
            cfg_clr   = ($urandom_range(0, 299) == 0);
            tick();
        end
        cfg_wr  = 1'b0;
        cfg_clr = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
